// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: sequences single/burst RAM accesses through the address decoder with a settle cycle before each enable
module ram_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [0:ADDR_W-1] req_addr,
  input  logic [1:0]        req_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_data_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic [0:ADDR_W-1] adress,
  output logic              enram,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, nxt;
  logic we_l, last;
  logic [1:0] beats_left;
  logic [3:0] wcnt;
  assign last = state == ACCESS && wcnt == 4'd0;
  assign busy = state != IDLE;
  assign wr_data_ready = state == SETUP && we_l;
  always_comb begin
    nxt = state == IDLE ? (req_valid && req_ready ? SETUP : IDLE) :
          state == SETUP ? ACCESS :
          !last ? ACCESS :
          beats_left == 2'd0 ? IDLE : SETUP;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      req_ready <= 1'b0;
      enram <= 1'b0;
      ram_we <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      ram_wdata <= '0;
      adress <= '0;
      we_l <= 1'b0;
      beats_left <= 2'd0;
      wcnt <= 4'd0;
    end else begin
      state <= nxt;
      req_ready <= nxt == IDLE;
      enram <= nxt == ACCESS;
      ram_we <= nxt == ACCESS && we_l;
      rd_valid <= last && !we_l;
      if (last && !we_l) rd_data <= ram_rdata;
      if (state == IDLE && req_valid && req_ready) begin
        we_l <= req_we;
        adress <= req_addr;
        beats_left <= req_len;
      end
      if (state == SETUP) wcnt <= 4'(WAIT_CYC);
      if (state == SETUP && we_l) ram_wdata <= wr_data;
      if (state == ACCESS && !last) wcnt <= wcnt - 4'd1;
      if (last && beats_left != 2'd0) begin
        adress <= adress + ADDR_W'(1);
        beats_left <= beats_left - 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: checks ram_access_ctrl against a transaction timeline model and a shadow memory
module tb_ram_access_ctrl;
  localparam int W = 1;
  logic clk, rst, req_valid, req_we;
  logic [0:7] req_addr;
  logic [1:0] req_len;
  logic [7:0] wr_data, ram_rdata, rd_data, ram_wdata;
  logic req_ready, wr_data_ready, rd_valid, busy, enram, ram_we;
  logic [0:7] adress;
  logic req_ready1, wr_data_ready1, rd_valid1, busy1, enram1, ram_we1;
  logic [7:0] rd_data1, ram_wdata1;
  logic [0:7] adress1;
  bit [7:0] mem [256];
  bit [255:0] wflag;
  logic [7:0] shadow [256];
  int vecs = 0, errs = 0;

  typedef struct {
    logic we;
    logic [7:0] addr;
    logic [1:0] len;
    logic [3:0][7:0] wd;
    logic [3:0][7:0] er;
  } txn_t;
  txn_t tbl [5];

  ram_access_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_CYC(W)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data), .wr_data_ready(wr_data_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .adress(adress), .enram(enram),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

  ram_access_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_CYC(0)) u1 (
    .clk(clk), .rst(rst), .req_valid(1'b1), .req_ready(req_ready1), .req_we(1'b0),
    .req_addr(8'h10), .req_len(2'b00), .wr_data(8'h00), .wr_data_ready(wr_data_ready1),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1), .adress(adress1), .enram(enram1),
    .ram_we(ram_we1), .ram_wdata(ram_wdata1), .ram_rdata(8'h00));

  always #5 clk = ~clk;

  always @(posedge clk) if (enram && ram_we) begin
    mem[adress] <= ram_wdata;
    wflag[adress] <= 1'b1;
  end
  assign ram_rdata = !enram ? 8'h00 : wflag[adress] ? mem[adress] : (adress ^ 8'hA5);

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic run_txn(input logic we, input logic [7:0] addr, input logic [1:0] len,
                         input logic [3:0][7:0] wd, input logic [3:0][7:0] er, input int stop_at);
    int n, tot, b, p, rb;
    logic rv;
    logic [7:0] ea;
    logic [5:0] ef;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    req_len = len;
    tot = (int'(len) + 1) * (W + 2);
    for (int k = 1; k <= tot + 1; k++) begin
      @(negedge clk);
      if (k == stop_at) return;
      b = k <= tot ? (k - 1) / (W + 2) : int'(len);
      p = (k - 1) % (W + 2);
      ea = 8'(int'(addr) + b);
      rv = !we && k >= W + 3 && ((k - W - 3) % (W + 2)) == 0;
      rb = (k - W - 3) / (W + 2);
      ef = {k > tot, k <= tot, k <= tot && p > 0, k <= tot && p > 0 && we,
            k <= tot && p == 0 && we, rv};
      chk("ctl", 32'({req_ready, busy, enram, ram_we, wr_data_ready, rd_valid}), 32'(ef));
      if (k <= tot) chk("adress", 32'(adress), 32'(ea));
      if (k <= tot && p > 0 && we) chk("ram_wdata", 32'(ram_wdata), 32'(wd[b]));
      if (rv) chk("rd_data", 32'(rd_data), 32'(er[rb]));
      if (we && k <= tot && p == W + 1) shadow[ea] = wd[b];
      req_valid = k < tot ? 1'($urandom) : 1'b0;
      req_addr = 8'($urandom);
      req_we = 1'($urandom);
      req_len = 2'($urandom);
      wr_data = (k <= tot && p == 0) ? wd[b] : 8'($urandom);
    end
  endtask

  initial begin
    logic [3:0][7:0] wd, er;
    logic we;
    logic [7:0] addr;
    logic [1:0] len;
    int last, acc;
    tbl[0] = '{1'b1, 8'h2A, 2'd0, {8'h00, 8'h00, 8'h00, 8'h5C}, 32'h0};
    tbl[1] = '{1'b0, 8'h2A, 2'd0, 32'h0, {8'h00, 8'h00, 8'h00, 8'h5C}};
    tbl[2] = '{1'b0, 8'hFE, 2'd3, 32'h0, {8'hA4, 8'hA5, 8'h5A, 8'h5B}};
    tbl[3] = '{1'b1, 8'hFF, 2'd1, {8'h00, 8'h00, 8'h22, 8'h11}, 32'h0};
    tbl[4] = '{1'b0, 8'hFE, 2'd2, 32'h0, {8'h00, 8'h22, 8'h11, 8'h5B}};
    for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'hA5;
    clk = 0;
    rst = 1;
    req_valid = 0;
    req_we = 0;
    req_addr = 0;
    req_len = 0;
    wr_data = 0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", 32'({req_ready, busy, enram, ram_we, wr_data_ready, rd_valid, adress, ram_wdata, rd_data}), 32'd0);
    end
    rst = 0;
    @(negedge clk);
    chk("idle_after_reset", 32'({req_ready, busy, enram}), 32'b100);
    for (int i = 0; i < 5; i++) run_txn(tbl[i].we, tbl[i].addr, tbl[i].len, tbl[i].wd, tbl[i].er, 0);
    wd = {8'h44, 8'h33, 8'h77, 8'h66};
    run_txn(1'b1, 8'h40, 2'd3, wd, 32'h0, 5);
    chk("mid_burst_enram", 32'({enram, ram_we}), 32'b11);
    rst = 1;
    req_valid = 0;
    #1;
    chk("abort_outs", 32'({req_ready, busy, enram, ram_we, wr_data_ready, rd_valid}), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_hold", 32'({busy, enram, ram_we, wr_data_ready}), 32'd0);
    end
    rst = 0;
    @(negedge clk);
    run_txn(1'b0, 8'h40, 2'd1, 32'h0, {16'h0, shadow[8'h41], shadow[8'h40]}, 0);
    repeat (20) begin
      we = 1'($urandom);
      addr = 8'($urandom);
      len = 2'($urandom);
      wd = $urandom;
      for (int i = 0; i < 4; i++) er[i] = shadow[8'(int'(addr) + i)];
      run_txn(we, addr, len, wd, er, 0);
    end
    last = -1;
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("u1_ready_busy", 32'(req_ready1 && busy1), 32'd0);
      if (req_ready1) begin
        if (last >= 0) chk("u1_spacing", 32'(c - last), 32'd3);
        last = c;
        acc++;
      end
    end
    chk("u1_accepts", 32'(acc >= 9), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
